// File: rtl/code_input.sv
// Digit-entry and verification core of the keypad code lock: collects debounced
// digits into a sequence that either replaces the stored code or is checked against it.
module code_input #(
    parameter int CODE_LEN = 6,
    parameter int DIGIT_W  = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = '0
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               codeSet_t,
    input  logic               keySured,
    input  logic [DIGIT_W-1:0] keyValue,
    output logic               codeFinish,
    output logic               success,
    output logic               ledSet
);

    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int CNT_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam logic [CNT_W-1:0]   LAST_IDX  = CNT_W'(CODE_LEN - 1);
    localparam logic [DIGIT_W-1:0] MAX_DIGIT = DIGIT_W'(9);

    typedef enum logic {
        VERIFY = 1'b0,
        SET    = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   digitCount;
    logic [CODE_W-1:0]  entryBuf;
    logic [CODE_W-1:0]  storedCode;
    logic [CODE_W-1:0]  nextBuf;
    logic               ksD;
    logic               csD;
    logic               keyEvt;
    logic               setEvt;
    logic               keyAccept;

    // One event per rising edge of each level input, however long it is held.
    assign keyEvt    = keySured & ~ksD;
    assign setEvt    = codeSet_t & ~csD;
    assign keyAccept = keyEvt && (keyValue <= MAX_DIGIT);

    // New digits enter at the LS nibble, so the first digit ends up in the MS nibble.
    assign nextBuf = {entryBuf[CODE_W-DIGIT_W-1:0], keyValue};

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every register here sees
        // the pre-edge values of the others regardless of statement order.
        if (n_rst) begin
            state      <= VERIFY;
            digitCount <= '0;
            entryBuf   <= '0;
            // NOTE: the stored code is an ordinary register, not a memory, so it
            // is reset explicitly to the factory default.
            storedCode <= DEFAULT_CODE;
            codeFinish <= 1'b0;
            success    <= 1'b0;
            ledSet     <= 1'b0;
            ksD        <= 1'b0;
            csD        <= 1'b0;
        end else begin
            ksD        <= keySured;
            csD        <= codeSet_t;
            codeFinish <= 1'b0;

            if (setEvt) begin
                // Set request takes priority; a key edge in the same cycle is dropped.
                state      <= SET;
                ledSet     <= 1'b1;
                digitCount <= '0;
                entryBuf   <= '0;
                success    <= 1'b0;
            end else if (keyAccept) begin
                entryBuf <= nextBuf;
                if (digitCount == '0) begin
                    success <= 1'b0;
                end
                if (digitCount == LAST_IDX) begin
                    digitCount <= '0;
                    codeFinish <= 1'b1;
                    if (state == SET) begin
                        storedCode <= nextBuf;
                        success    <= 1'b0;
                        state      <= VERIFY;
                        ledSet     <= 1'b0;
                    end else begin
                        success <= (nextBuf == storedCode);
                    end
                end else begin
                    digitCount <= digitCount + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_code_input.sv
// Self-checking bench for code_input: directed scenarios plus randomized code
// sessions, checked against an event-level model of the lock's digit rules.
module tb_code_input;

    localparam int CODE_LEN = 6;
    localparam int DIGIT_W  = 4;

    logic               clk = 1'b0;
    logic               n_rst;
    logic               codeSet_t;
    logic               keySured;
    logic [DIGIT_W-1:0] keyValue;
    logic               codeFinish;
    logic               success;
    logic               ledSet;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model: mode flag, digits entered so far, stored code digits.
    bit mSetMode;
    bit mSuccess;
    int mEntry[$];
    int mStored[CODE_LEN];

    code_input #(
        .CODE_LEN    (CODE_LEN),
        .DIGIT_W     (DIGIT_W),
        .DEFAULT_CODE(24'h000000)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .codeSet_t (codeSet_t),
        .keySured  (keySured),
        .keyValue  (keyValue),
        .codeFinish(codeFinish),
        .success   (success),
        .ledSet    (ledSet)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mSetMode = 1'b0;
        mSuccess = 1'b0;
        mEntry.delete();
        for (int i = 0; i < CODE_LEN; i++) mStored[i] = 0;
    endtask

    task automatic model_set();
        mSetMode = 1'b1;
        mSuccess = 1'b0;
        mEntry.delete();
    endtask

    task automatic model_key(input int d, output bit fin);
        bit same;
        fin = 1'b0;
        if (d > 9) return;
        if (mEntry.size() == 0) mSuccess = 1'b0;
        mEntry.push_back(d);
        if (mEntry.size() == CODE_LEN) begin
            fin = 1'b1;
            if (mSetMode) begin
                for (int i = 0; i < CODE_LEN; i++) mStored[i] = mEntry[i];
                mSuccess = 1'b0;
                mSetMode = 1'b0;
            end else begin
                same = 1'b1;
                for (int i = 0; i < CODE_LEN; i++)
                    if (mEntry[i] != mStored[i]) same = 1'b0;
                mSuccess = same;
            end
            mEntry.delete();
        end
    endtask

    // One key press: rising edge at a negedge, checks one clock after capture,
    // then counts any stray codeFinish pulses over the rest of the press.
    task automatic press(input int d, input int highCyc, input int lowCyc);
        bit fin;
        int extra;
        @(negedge clk);
        keySured = 1'b1;
        keyValue = DIGIT_W'(d);
        model_key(d, fin);
        @(negedge clk);
        nCompared++;
        if (codeFinish !== fin) begin
            nMismatched++;
            $display("FAIL finish_on_capture digit=%0d: got %b want %b", d, codeFinish, fin);
        end
        nCompared++;
        if (success !== mSuccess) begin
            nMismatched++;
            $display("FAIL success_on_capture digit=%0d: got %b want %b", d, success, mSuccess);
        end
        nCompared++;
        if (ledSet !== mSetMode) begin
            nMismatched++;
            $display("FAIL ledSet_on_capture digit=%0d: got %b want %b", d, ledSet, mSetMode);
        end
        extra = 0;
        repeat (highCyc - 1) begin
            @(negedge clk);
            if (codeFinish !== 1'b0) extra++;
        end
        keySured = 1'b0;
        keyValue = DIGIT_W'($urandom_range(0, 15));
        repeat (lowCyc) begin
            @(negedge clk);
            if (codeFinish !== 1'b0) extra++;
        end
        nCompared++;
        if (extra != 0) begin
            nMismatched++;
            $display("FAIL finish_extra_pulse digit=%0d: got %0d extra cycles want 0", d, extra);
        end
        nCompared++;
        if (success !== mSuccess) begin
            nMismatched++;
            $display("FAIL success_held digit=%0d: got %b want %b", d, success, mSuccess);
        end
    endtask

    task automatic set_pulse(input int highCyc, input bit withKey, input int d);
        @(negedge clk);
        codeSet_t = 1'b1;
        if (withKey) begin
            keySured = 1'b1;
            keyValue = DIGIT_W'(d);
        end
        model_set();
        @(negedge clk);
        nCompared++;
        if (ledSet !== 1'b1 || success !== 1'b0 || codeFinish !== 1'b0) begin
            nMismatched++;
            $display("FAIL set_entry: got led=%b succ=%b fin=%b want led=1 succ=0 fin=0",
                     ledSet, success, codeFinish);
        end
        repeat (highCyc - 1) @(negedge clk);
        codeSet_t = 1'b0;
        keySured  = 1'b0;
        repeat (3) @(negedge clk);
        nCompared++;
        if (ledSet !== 1'b1) begin
            nMismatched++;
            $display("FAIL set_held: got ledSet=%b want 1", ledSet);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        n_rst     = 1'b1;
        codeSet_t = 1'b0;
        keySured  = 1'b0;
        repeat (cycles) @(negedge clk);
        model_reset();
        nCompared++;
        if (codeFinish !== 1'b0 || success !== 1'b0 || ledSet !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_outputs: got fin=%b succ=%b led=%b want 0 0 0",
                     codeFinish, success, ledSet);
        end
        n_rst = 1'b0;
    endtask

    task automatic enter_code(input int digits[CODE_LEN], input int highCyc, input int lowCyc);
        for (int i = 0; i < CODE_LEN; i++) press(digits[i], highCyc, lowCyc);
    endtask

    task automatic test_reset();
        do_reset(5);
        // A 25-cycle hold must count once: finish arrives exactly on the sixth press.
        enter_code('{3, 1, 4, 1, 5, 9}, 25, 3);
    endtask

    task automatic test_set_code();
        set_pulse(10, 1'b0, 0);
        enter_code('{0, 1, 2, 3, 4, 5}, 25, 3);
    endtask

    task automatic test_wrong_code();
        enter_code('{1, 3, 5, 7, 9, 0}, 25, 3);
        enter_code('{1, 3, 5, 7, 9, 0}, 25, 3);
    endtask

    task automatic test_right_code();
        enter_code('{0, 1, 2, 3, 4, 5}, 25, 3);
        nCompared++;
        if (success !== 1'b1) begin
            nMismatched++;
            $display("FAIL right_code_success: got %b want 1", success);
        end
        press(7, 25, 3);
        nCompared++;
        if (success !== 1'b0) begin
            nMismatched++;
            $display("FAIL next_digit_clears: got %b want 0", success);
        end
    endtask

    task automatic test_edge_cases();
        press(12, 25, 3);
        enter_code('{0, 1, 2, 3, 4, 0}, 6, 2);
        press(0, 4, 2);
        press(1, 4, 2);
        press(2, 4, 2);
        press(14, 4, 2);
        press(3, 4, 2);
        press(4, 4, 2);
        press(5, 4, 2);
        // Key edge coincident with set edge must be discarded.
        set_pulse(5, 1'b1, 8);
        enter_code('{9, 8, 7, 6, 5, 4}, 3, 2);
        enter_code('{9, 8, 7, 6, 5, 4}, 3, 2);
        press(1, 3, 2);
        press(2, 3, 2);
        press(3, 3, 2);
        do_reset(2);
        enter_code('{0, 0, 0, 0, 0, 0}, 3, 2);
        nCompared++;
        if (success !== 1'b1) begin
            nMismatched++;
            $display("FAIL default_code_after_reset: got %b want 1", success);
        end
    endtask

    task automatic test_random();
        int code[CODE_LEN];
        for (int r = 0; r < 16; r++) begin
            if (($urandom % 3) == 0) set_pulse($urandom_range(1, 4), 1'b0, 0);
            for (int i = 0; i < CODE_LEN; i++) begin
                code[i] = (mSetMode || ($urandom % 2) == 0) ? $urandom_range(0, 9) : mStored[i];
                if (($urandom % 5) == 0)
                    press($urandom_range(10, 15), $urandom_range(1, 4), $urandom_range(1, 3));
                press(code[i], $urandom_range(1, 4), $urandom_range(1, 3));
            end
        end
    endtask

    initial begin
        n_rst     = 1'b1;
        codeSet_t = 1'b0;
        keySured  = 1'b0;
        keyValue  = '0;
        model_reset();
        test_reset();
        test_set_code();
        test_wrong_code();
        test_right_code();
        test_edge_cases();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
